// File: rtl/gpio_defaults_sequencer.sv
// rtl/gpio_defaults_sequencer.sv - GPIO default-config shadow registers with serial load sequencer
//
// Holds one CFG_WIDTH configuration word per GPIO channel and shifts all of
// them out to the GPIO control chain, followed by a one-cycle latch strobe.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   cfg_we/sel/wdata   single-channel shadow write (IDLE only)
//   restore            reload every shadow word from GPIO_CONFIG_INIT (IDLE only)
//   xfer_start         start a serial transfer of all shadow words
//   gpio_defaults      packed shadow words, channel i at [i*CFG_WIDTH +: CFG_WIDTH]
//   serial_clock/data  shift clock and data, highest channel first, MSB first
//   serial_load        latch strobe after the last bit
//   busy, done         transfer in progress / completion pulse
//   cfg_err            pulse for a rejected write or restore

module gpio_defaults_sequencer #(
    parameter int NUM_GPIO  = 2,
    parameter int CFG_WIDTH = 13,
    parameter logic [NUM_GPIO*CFG_WIDTH-1:0] GPIO_CONFIG_INIT = {NUM_GPIO{13'h0402}},
    parameter int AUTO_LOAD = 1,
    localparam int SEL_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          cfg_we,
    input  logic [SEL_W-1:0]              cfg_sel,
    input  logic [CFG_WIDTH-1:0]          cfg_wdata,
    input  logic                          restore,
    input  logic                          xfer_start,
    output logic [NUM_GPIO*CFG_WIDTH-1:0] gpio_defaults,
    output logic                          serial_clock,
    output logic                          serial_data,
    output logic                          serial_load,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    localparam int CH_W  = SEL_W;
    localparam int BIT_W = (CFG_WIDTH > 1) ? $clog2(CFG_WIDTH) : 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_GPIO - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_WIDTH - 1);
    localparam logic [SEL_W:0]   NUM_SEL  = (SEL_W + 1)'(NUM_GPIO);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    logic [CFG_WIDTH-1:0] shadow [NUM_GPIO];
    logic [1:0]           state;
    logic [CH_W-1:0]      ch_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 phase;
    // Stands in for xfer_start on the first edge after reset release.
    logic                 auto_pend;

    logic                 sel_ok;
    logic                 start;
    logic [CFG_WIDTH-1:0] cur_word;

    assign sel_ok   = ({1'b0, cfg_sel} < NUM_SEL);
    assign start    = xfer_start | auto_pend;
    assign cur_word = shadow[ch_cnt];

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_pack
        assign gpio_defaults[g*CFG_WIDTH +: CFG_WIDTH] = shadow[g];
    end

    // All serial outputs decode from state, so they drop to 0 the instant
    // reset asserts and are 0 throughout IDLE.
    assign busy         = (state != IDLE);
    assign serial_load  = (state == LOAD);
    assign serial_clock = (state == SHIFT) & phase;
    assign serial_data  = (state == SHIFT) & cur_word[BIT_LAST - bit_cnt];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                shadow[i] <= GPIO_CONFIG_INIT[i*CFG_WIDTH +: CFG_WIDTH];
            end
            state     <= IDLE;
            ch_cnt    <= '0;
            bit_cnt   <= '0;
            phase     <= 1'b0;
            auto_pend <= (AUTO_LOAD != 0);
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            auto_pend <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            case (state)
                IDLE: begin
                    // restore outranks a simultaneous write and suppresses its error.
                    if (restore) begin
                        for (int i = 0; i < NUM_GPIO; i++) begin
                            shadow[i] <= GPIO_CONFIG_INIT[i*CFG_WIDTH +: CFG_WIDTH];
                        end
                    end else if (cfg_we) begin
                        if (sel_ok) begin
                            shadow[cfg_sel] <= cfg_wdata;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                    if (start) begin
                        state   <= SHIFT;
                        ch_cnt  <= CH_LAST;
                        bit_cnt <= '0;
                        phase   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cfg_we || restore) begin
                        cfg_err <= 1'b1;
                    end
                    phase <= ~phase;
                    if (phase) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (ch_cnt == '0) begin
                                state <= LOAD;
                            end else begin
                                ch_cnt <= ch_cnt - 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (cfg_we || restore) begin
                        cfg_err <= 1'b1;
                    end
                    state   <= IDLE;
                    done    <= 1'b1;
                    ch_cnt  <= '0;
                    bit_cnt <= '0;
                    phase   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_defaults_sequencer.sv
// tb/tb_gpio_defaults_sequencer.sv - directed self-checking bench for gpio_defaults_sequencer
module tb_gpio_defaults_sequencer;

    localparam logic [25:0] INIT_A = {13'h1803, 13'h0402};
    localparam logic [38:0] INIT_B = {13'h0AAA, 13'h1803, 13'h0402};

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_sel = '0;
    logic [12:0] cfg_wdata = '0;
    logic        restore = 1'b0;
    logic        xfer_start = 1'b0;
    logic [25:0] gpio_defaults;
    logic        serial_clock, serial_data, serial_load, busy, done, cfg_err;

    logic        cfg_we_b = 1'b0;
    logic [1:0]  cfg_sel_b = '0;
    logic [12:0] cfg_wdata_b = '0;
    logic        restore_b = 1'b0;
    logic        xfer_start_b = 1'b0;
    logic [38:0] gpio_defaults_b;
    logic        serial_clock_b, serial_data_b, serial_load_b, busy_b, done_b, cfg_err_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gpio_defaults_sequencer #(
        .NUM_GPIO(2), .CFG_WIDTH(13), .GPIO_CONFIG_INIT(INIT_A), .AUTO_LOAD(1)
    ) u_dut (
        .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_wdata(cfg_wdata), .restore(restore), .xfer_start(xfer_start),
        .gpio_defaults(gpio_defaults), .serial_clock(serial_clock),
        .serial_data(serial_data), .serial_load(serial_load), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    // Three channels so that cfg_sel can address a channel that does not exist.
    gpio_defaults_sequencer #(
        .NUM_GPIO(3), .CFG_WIDTH(13), .GPIO_CONFIG_INIT(INIT_B), .AUTO_LOAD(0)
    ) u_dut_b (
        .clk(clk), .resetn(resetn), .cfg_we(cfg_we_b), .cfg_sel(cfg_sel_b),
        .cfg_wdata(cfg_wdata_b), .restore(restore_b), .xfer_start(xfer_start_b),
        .gpio_defaults(gpio_defaults_b), .serial_clock(serial_clock_b),
        .serial_data(serial_data_b), .serial_load(serial_load_b), .busy(busy_b),
        .done(done_b), .cfg_err(cfg_err_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after the stimulus that starts a transfer was applied at a
    // falling edge. Collects the shifted bits and pulse counts until idle.
    task automatic capture(output logic [63:0] bits, output int nbits, output int nbusy,
                           output int nload, output int ndone, output int nphase_err,
                           output int timeout);
        logic seen_busy;
        logic d_phase0;
        int   tail;
        bits = '0; nbits = 0; nbusy = 0; nload = 0; ndone = 0; nphase_err = 0;
        timeout = 1; seen_busy = 1'b0; d_phase0 = 1'b0; tail = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                xfer_start = 1'b0;
                cfg_we     = 1'b0;
                restore    = 1'b0;
            end
            if (busy) begin
                seen_busy = 1'b1;
                nbusy++;
            end
            if (serial_load) nload++;
            if (done) ndone++;
            if (busy && !serial_load) begin
                if (!serial_clock) begin
                    d_phase0 = serial_data;
                end else begin
                    if (serial_data !== d_phase0) nphase_err++;
                    bits = {bits[62:0], serial_data};
                    nbits++;
                end
            end
            if (seen_busy && !busy) begin
                tail++;
                if (tail == 3) begin
                    timeout = 0;
                    break;
                end
            end
        end
    endtask

    logic [63:0] bits;
    int nbits, nbusy, nload, ndone, nperr, tmo;
    int guard;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sclk", serial_clock, 1'b0);
        check_eq("rst_sdata", serial_data, 1'b0);
        check_eq("rst_sload", serial_load, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_cfg_err", cfg_err, 1'b0);
        check_eq("rst_shadow", gpio_defaults, INIT_A);
        check_eq("rst_shadow_b", gpio_defaults_b, INIT_B);

        // Automatic transfer after reset release
        resetn = 1'b1;
        capture(bits, nbits, nbusy, nload, ndone, nperr, tmo);
        check_eq("auto_timeout", tmo, 0);
        check_eq("auto_bits", bits[25:0], 26'h3006402);
        check_eq("auto_nbits", nbits, 26);
        check_eq("auto_busy_len", nbusy, 53);
        check_eq("auto_load_cnt", nload, 1);
        check_eq("auto_done_cnt", ndone, 1);
        check_eq("auto_phase_hold", nperr, 0);
        check_eq("noauto_b_idle", busy_b, 1'b0);

        // Single write in IDLE, then transfer
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 13'h1FFF;
        @(negedge clk);
        cfg_we = 1'b0;
        check_eq("wr_shadow", gpio_defaults, 26'h3007FFF);
        check_eq("wr_no_err", cfg_err, 1'b0);
        xfer_start = 1'b1;
        capture(bits, nbits, nbusy, nload, ndone, nperr, tmo);
        check_eq("wr_xfer_bits", bits[25:0], 26'h3007FFF);
        check_eq("wr_last13_ones", bits[12:0], 13'h1FFF);
        check_eq("wr_busy_len", nbusy, 53);

        // Write in the same cycle as xfer_start is part of that transfer
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_wdata = 13'h0155; xfer_start = 1'b1;
        capture(bits, nbits, nbusy, nload, ndone, nperr, tmo);
        check_eq("same_cyc_bits", bits[25:0], {13'h0155, 13'h1FFF});
        check_eq("same_cyc_done", ndone, 1);

        // Writes and restore while busy are rejected; xfer_start is silent
        xfer_start = 1'b1;
        @(negedge clk);
        xfer_start = 1'b0;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_wdata = 13'h0000;
        @(negedge clk);
        cfg_we = 1'b0;
        check_eq("busy_wr_err", cfg_err, 1'b1);
        check_eq("busy_wr_shadow", gpio_defaults, {13'h0155, 13'h1FFF});
        restore = 1'b1;
        @(negedge clk);
        restore = 1'b0;
        check_eq("busy_rst_err", cfg_err, 1'b1);
        check_eq("busy_rst_shadow", gpio_defaults, {13'h0155, 13'h1FFF});
        xfer_start = 1'b1;
        @(negedge clk);
        xfer_start = 1'b0;
        check_eq("busy_xfer_silent", cfg_err, 1'b0);
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("busy_drain_bound", (guard < 200), 1'b1);
        check_eq("busy_done_pulse", done, 1'b1);
        @(negedge clk);
        check_eq("busy_no_restart", busy, 1'b0);

        // restore + cfg_we in the same IDLE cycle
        restore = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 13'h0AAA;
        @(negedge clk);
        restore = 1'b0; cfg_we = 1'b0;
        check_eq("restore_wins", gpio_defaults, INIT_A);
        check_eq("restore_no_err", cfg_err, 1'b0);

        // Out-of-range channel select on the three-channel instance
        cfg_we_b = 1'b1; cfg_sel_b = 2'd3; cfg_wdata_b = 13'h1FFF;
        @(negedge clk);
        cfg_we_b = 1'b0;
        check_eq("oor_err", cfg_err_b, 1'b1);
        check_eq("oor_shadow", gpio_defaults_b, INIT_B);
        @(negedge clk);
        check_eq("oor_err_one_cycle", cfg_err_b, 1'b0);
        cfg_we_b = 1'b1; cfg_sel_b = 2'd2; cfg_wdata_b = 13'h0001;
        @(negedge clk);
        cfg_we_b = 1'b0;
        check_eq("b_ch2_write", gpio_defaults_b, {13'h0001, 13'h1803, 13'h0402});
        check_eq("b_ch2_no_err", cfg_err_b, 1'b0);

        // Reset at bit 10 of a transfer aborts it, then auto-load restarts
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 13'h1234;
        xfer_start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; xfer_start = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("mid_busy_before", busy, 1'b1);
        #1 resetn = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_sclk", serial_clock, 1'b0);
        check_eq("mid_rst_sdata", serial_data, 1'b0);
        check_eq("mid_rst_shadow", gpio_defaults, INIT_A);
        nload = 0; ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (serial_load) nload++;
            if (done) ndone++;
        end
        check_eq("mid_rst_no_load", nload, 0);
        check_eq("mid_rst_no_done", ndone, 0);
        resetn = 1'b1;
        capture(bits, nbits, nbusy, nload, ndone, nperr, tmo);
        check_eq("restart_timeout", tmo, 0);
        check_eq("restart_bits", bits[25:0], 26'h3006402);
        check_eq("restart_busy_len", nbusy, 53);
        check_eq("restart_load", nload, 1);
        check_eq("restart_done", ndone, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
